// File: rtl/dcache_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// dcache_req_arbiter_pkg : shared constants, MAT codes and arbiter states
// Rev 1.0
// ============================================================================
package dcache_req_arbiter_pkg;

  localparam int DC_ADDR_W   = 32;
  localparam int DC_DATA_W   = 32;
  localparam int DC_SB_PTR_W = 3;

  typedef enum logic [1:0] {
    MAT_SUC = 2'd0,
    MAT_CC  = 2'd1,
    MAT_WUC = 2'd2
  } mat_e;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_store_credit.sv
`default_nettype none
// ============================================================================
// dcache_store_credit : outstanding-store credit pool and completion register
// Rev 1.0
// ============================================================================
module dcache_store_credit #(
  parameter int MAX_OUTST = 2,
  parameter int SB_PTR_W  = 3,
  parameter int CRED_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_take,
  input  logic                i_resp_valid,
  input  logic [SB_PTR_W-1:0] i_resp_ptr,
  output logic [CRED_W-1:0]   o_credits,
  output logic                o_back_valid,
  output logic [SB_PTR_W-1:0] o_back_ptr
);

  localparam logic [CRED_W-1:0] C_MAX = CRED_W'(MAX_OUTST);

  logic [CRED_W-1:0]   credits_q, credits_d;
  logic                back_valid_q;
  logic [SB_PTR_W-1:0] back_ptr_q;

  // Saturate both ways so stray responses after a reset cannot overflow.
  always_comb begin
    credits_d = credits_q;
    if (i_take && !i_resp_valid) begin
      if (credits_q != '0) credits_d = credits_q - 1'b1;
    end else if (i_resp_valid && !i_take) begin
      if (credits_q != C_MAX) credits_d = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q    <= C_MAX;
      back_valid_q <= 1'b0;
      back_ptr_q   <= '0;
    end else begin
      credits_q    <= credits_d;
      back_valid_q <= i_resp_valid;
      back_ptr_q   <= i_resp_ptr;
    end
  end

  assign o_credits    = credits_q;
  assign o_back_valid = back_valid_q;
  assign o_back_ptr   = back_ptr_q;

endmodule
`default_nettype wire

// File: rtl/dcache_req_arbiter.sv
`default_nettype none
// ============================================================================
// dcache_req_arbiter : Dcache request port arbiter between loads and store drain
// Rev 1.0
// ============================================================================
module dcache_req_arbiter
  import dcache_req_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DC_ADDR_W,
  parameter int DATA_W     = DC_DATA_W,
  parameter int LD_TAG_W   = 4,
  parameter int SB_PTR_W   = DC_SB_PTR_W,
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_MAX = 4,
  parameter int TAG_W      = max_int(LD_TAG_W, SB_PTR_W)
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                LdValid,
  input  logic [LD_TAG_W-1:0] LdTag,
  input  logic [ADDR_W-1:0]   LdAddr,
  output logic                LdAck,
  input  logic                SbValid,
  input  logic [SB_PTR_W-1:0] SbPtr,
  input  logic [1:0]          SbMat,
  input  logic [ADDR_W-1:0]   SbAddr,
  input  logic [DATA_W-1:0]   SbData,
  output logic                SbAck,
  input  logic                SbEmpty,
  input  logic                DrainReq,
  output logic                DrainDone,
  input  logic                Flush,
  output logic                DcReqValid,
  input  logic                DcReqReady,
  output logic                DcReqIsStore,
  output logic [TAG_W-1:0]    DcReqTag,
  output logic [ADDR_W-1:0]   DcReqAddr,
  output logic [DATA_W-1:0]   DcReqData,
  output logic [1:0]          DcReqMat,
  input  logic                DcStRespValid,
  input  logic [SB_PTR_W-1:0] DcStRespPtr,
  output logic                SbBackAble,
  output logic [SB_PTR_W-1:0] SbBackPtr
);

  localparam int CRED_W = $clog2(MAX_OUTST + 1);
  localparam int STV_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CRED_W-1:0] C_CRED_MAX   = CRED_W'(MAX_OUTST);
  localparam logic [STV_W-1:0]  C_STARVE_MAX = STV_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic                req_valid_q, req_valid_d;
  logic                req_is_store_q, req_is_store_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  mat_e                req_mat_q, req_mat_d;

  logic [CRED_W-1:0]   credits;
  logic                free, drain_mode, st_ok, ld_ok, st_first;
  logic                st_cap, ld_cap, drain_done;

  dcache_store_credit #(
    .MAX_OUTST (MAX_OUTST),
    .SB_PTR_W  (SB_PTR_W),
    .CRED_W    (CRED_W)
  ) u_credit (
    .clk          (Clk),
    .rst_n        (Rest),
    .i_take       (st_cap),
    .i_resp_valid (DcStRespValid),
    .i_resp_ptr   (DcStRespPtr),
    .o_credits    (credits),
    .o_back_valid (SbBackAble),
    .o_back_ptr   (SbBackPtr)
  );

  // DrainReq blocks loads in the very cycle it is raised, before DRAIN is entered.
  always_comb begin
    free       = ~req_valid_q | DcReqReady;
    drain_mode = (state_q == DRAIN) | DrainReq;
    st_ok      = SbValid & (credits != '0);
    ld_ok      = LdValid & ~Flush & ~drain_mode;
    st_first   = st_ok & (drain_mode | (starve_q == C_STARVE_MAX) | ~ld_ok);
    st_cap     = Rest & free & st_first;
    ld_cap     = Rest & free & ld_ok & ~st_first;
  end

  always_comb begin
    req_valid_d    = req_valid_q;
    req_is_store_d = req_is_store_q;
    req_tag_d      = req_tag_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    req_mat_d      = req_mat_q;
    if (st_cap) begin
      req_valid_d    = 1'b1;
      req_is_store_d = 1'b1;
      req_tag_d      = TAG_W'(SbPtr);
      req_addr_d     = SbAddr;
      req_data_d     = SbData;
      req_mat_d      = mat_e'(SbMat);
    end else if (ld_cap) begin
      req_valid_d    = 1'b1;
      req_is_store_d = 1'b0;
      req_tag_d      = TAG_W'(LdTag);
      req_addr_d     = LdAddr;
      req_data_d     = '0;
      req_mat_d      = MAT_SUC;
    end else if (req_valid_q && (DcReqReady || (Flush && !req_is_store_q))) begin
      // Accepted, or an unaccepted load squashed by flush; stores always survive.
      req_valid_d    = 1'b0;
      req_is_store_d = 1'b0;
      req_tag_d      = '0;
      req_addr_d     = '0;
      req_data_d     = '0;
      req_mat_d      = MAT_SUC;
    end
  end

  always_comb begin
    starve_d = '0;
    if (SbValid && !st_cap) begin
      starve_d = (starve_q == C_STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      ARB: begin
        if (DrainReq) state_d = DRAIN;
      end
      DRAIN: begin
        if (SbEmpty && (credits == C_CRED_MAX) && !(req_valid_q && req_is_store_q)) begin
          drain_done = Rest;
          state_d    = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q        <= ARB;
      starve_q       <= '0;
      req_valid_q    <= 1'b0;
      req_is_store_q <= 1'b0;
      req_tag_q      <= '0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      req_mat_q      <= MAT_SUC;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      req_valid_q    <= req_valid_d;
      req_is_store_q <= req_is_store_d;
      req_tag_q      <= req_tag_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      req_mat_q      <= req_mat_d;
    end
  end

  assign LdAck        = ld_cap;
  assign SbAck        = st_cap;
  assign DrainDone    = drain_done;
  assign DcReqValid   = req_valid_q;
  assign DcReqIsStore = req_is_store_q;
  assign DcReqTag     = req_tag_q;
  assign DcReqAddr    = req_addr_q;
  assign DcReqData    = req_data_q;
  assign DcReqMat     = req_mat_q;

endmodule
`default_nettype wire

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Arbitrates the single Dcache request port between the load pipe and the store-buffer drain path.
- Loads get priority by default; a starvation counter, a drain mode and a store credit pool keep committed stores moving.
- Owns the store handshake: grant pulse (store moves to wait-commit), outstanding-store credits, and a completion pulse back to the store buffer.
- Sits between the AGU load stage, the store buffer and the Dcache.

Parameters:
- ADDR_W, 32, physical address width
- DATA_W, 32, store data width
- LD_TAG_W, 4, load request tag width
- SB_PTR_W, 3, store-buffer entry pointer width (entries 1..7; 0 = none)
- MAX_OUTST, 2, max stores accepted by Dcache but not yet completed
- STARVE_MAX, 4, consecutive cycles a pending store may lose to loads

Ports:
- Clk in 1: clock
- Rest in 1: async active-low reset
- LdValid in 1: load request pending
- LdTag in LD_TAG_W: load tag
- LdAddr in ADDR_W: load physical address
- LdAck out 1: load captured (1-cycle pulse)
- SbValid in 1: store buffer has an entry in SWING state
- SbPtr in SB_PTR_W: that entry's index
- SbMat in 2: memory access type
- SbAddr in ADDR_W: store physical address
- SbData in DATA_W: store data
- SbAck out 1: store captured; store buffer moves the entry to SWEITCOM (1-cycle pulse)
- SbEmpty in 1: store buffer empty
- DrainReq in 1: level request to drain all stores (fence, ll/sc, CSR)
- DrainDone out 1: drain complete (1-cycle pulse)
- Flush in 1: pipeline flush
- DcReqValid out 1: request to Dcache
- DcReqReady in 1: Dcache accepts the request
- DcReqIsStore out 1: request is a store
- DcReqTag out max(LD_TAG_W,SB_PTR_W): load tag or store pointer, zero-extended
- DcReqAddr out ADDR_W: request address
- DcReqData out DATA_W: store data (0 for loads)
- DcReqMat out 2: MAT (0 for loads)
- DcStRespValid in 1: store completed in Dcache
- DcStRespPtr in SB_PTR_W: pointer of the completed store
- SbBackAble out 1: store completion to store buffer
- SbBackPtr out SB_PTR_W: pointer of the completed store

Behaviour:
- Reset (Rest=0, async): every output 0; state ARB; credits=MAX_OUTST; starve counter 0; request register cleared.
- Issue slot: slot is free when `free = ~DcReqValid | DcReqReady`. A capture happens only in a cycle with `free=1`.
- Capture timing: capture at cycle N → DcReqValid=1 from N+1. LdAck/SbAck pulse combinationally in cycle N; the requester advances at N+1.
- Hold rule: DcReqValid and all request fields stay stable until DcReqReady. The only exception is a flushed load (see below).
- Back-to-back: a capture in the same cycle as DcReqReady gives back-to-back requests with no bubble.
- Store eligibility: `stOK = SbValid & (credits>0)`. Loads are eligible only when `LdValid & ~Flush & state==ARB`.
- Selection order, in ARB state:
  - store, if `stOK & (state==DRAIN | starve==STARVE_MAX | ~LdValid)`;
  - else load, if eligible;
  - else store, if `stOK`.
- Starve counter:
  - +1 per cycle with `SbValid & ~SbAck`, saturating at STARVE_MAX;
  - cleared on SbAck and when SbValid=0.
- Credits:
  - −1 on a store capture; +1 on DcStRespValid;
  - both in the same cycle gives net 0;
  - never below 0 or above MAX_OUTST.
- Store completion: SbBackAble/SbBackPtr are a registered copy of DcStRespValid/DcStRespPtr (1-cycle latency).
- Flush:
  - an unaccepted held load is dropped: DcReqValid=0 next cycle, unless DcReqReady is seen in the same cycle;
  - held and outstanding stores are never dropped (they are committed);
  - no load capture in the Flush cycle.
- State machine:
  - ARB → DRAIN on DrainReq (checked in the same cycle, so loads are blocked immediately).
  - DRAIN: stores only. When `SbEmpty & credits==MAX_OUTST & ~(DcReqValid & DcReqIsStore)`, pulse DrainDone and return to ARB.
  - If DrainReq drops early, drain still completes.
- DrainReq while already empty: DrainDone pulses the next cycle.
- Reset mid-operation: all state is discarded; in-flight Dcache responses after reset are ignored and do not overflow credits.

Decomposition:
- Shared package: MAT encodings, the SB_PTR_W/ADDR_W/DATA_W constants, and the arbiter state encoding (ARB, DRAIN).
- One sub-module, `dcache_store_credit`: credit counter plus response register feeding SbBackAble/SbBackPtr.

Test Plan:
- Loads only: LdValid=1 for 3 cycles, DcReqReady=1 → LdAck each cycle; DcReqValid from cycle 2 with tags 1,2,3; DcReqIsStore=0.
- Starvation: LdValid and SbValid (ptr=5) held, STARVE_MAX=4 → 4 load captures, then SbAck in cycle 5 with DcReqTag=5 and DcReqIsStore=1; counter back to 0.
- Credits: MAX_OUTST=2, three stores (ptr 1,2,3) and no responses → third store waits. DcStRespValid ptr=1 → SbBackAble/ptr=1 the next cycle; ptr 3 issues.
- Backpressure: DcReqReady=0 for 5 cycles with a store held → all fields stable and no new Ack; Flush during the hold does not drop the store.
- Flush drops a held load: load held with DcReqReady=0, Flush=1 → DcReqValid=0 next cycle, no LdAck for a new load that cycle.
- Drain: DrainReq with 2 stores pending and loads active → no LdAck until DrainDone. DrainDone pulses 1 cycle after the last response, once SbEmpty=1; async reset mid-drain → all outputs 0 immediately.
